// File: rtl/sprite_actor_ctrl.sv
// Player sprite controller: buttons -> clamped X steps, gravity jumps, animation select and sprite ROM address.
// Control outputs update on the causing edge; sprite_addr/in_sprite lag hCount/vCount by 1 clk; no backpressure.
module sprite_actor_ctrl #(
  parameter int SPR_W      = 32,
  parameter int SPR_H      = 32,
  parameter int X_MIN      = 143,
  parameter int X_MAX      = 702,
  parameter int Y_MIN      = 35,
  parameter int GROUND_Y   = 460,
  parameter int X_INIT     = 300,
  parameter int MOVE_DIV   = 500000,
  parameter int GRAV_DIV   = 1000000,
  parameter int ANIM_STEPS = 5,
  parameter int V_INIT     = 15,
  parameter int G          = 1,
  parameter int V_MAX      = 15,
  parameter int COOLDOWN   = 1000000,
  parameter int VW         = 7,
  parameter int ADDR_W     = $clog2(SPR_W * SPR_H)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              btn_left,
  input  logic              btn_right,
  input  logic              btn_jump,
  input  logic [9:0]        hCount,
  input  logic [9:0]        vCount,
  output logic [9:0]        pos_x,
  output logic [9:0]        pos_y,
  output logic              facing,
  output logic [1:0]        state,
  output logic [2:0]        sprite_sel,
  output logic [ADDR_W-1:0] sprite_addr,
  output logic              in_sprite
);

  localparam int MCW = (MOVE_DIV > 1) ? $clog2(MOVE_DIV) : 1;
  localparam int GCW = (GRAV_DIV > 1) ? $clog2(GRAV_DIV) : 1;
  localparam int CDW = $clog2(COOLDOWN + 1);
  localparam int SCW = $clog2(ANIM_STEPS + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, WALK = 2'd1, AIR = 2'd2} st_t;

  st_t                   st, st_n;
  logic [MCW-1:0]        move_cnt;
  logic [GCW-1:0]        grav_cnt;
  logic [CDW-1:0]        cool;
  logic [SCW-1:0]        step_cnt, step_cnt_n;
  logic                  walk_phase, walk_phase_n, facing_n, jump_q;
  logic signed [VW-1:0]  vel;
  logic [9:0]            disp_x, disp_y;

  logic                  go_l, go_r, dir_act, step, moved, tick, launch, land, bump, hit;
  logic signed [10:0]    vel_x, ny, vel_g;
  logic [10:0]           dx, dy;
  logic [ADDR_W-1:0]     addr_c;
  logic [2:0]            sel_n;

  assign state = st;

  always_comb begin
    go_l    = btn_left & ~btn_right;
    go_r    = btn_right & ~btn_left;
    dir_act = go_l | go_r;
    step    = dir_act && (move_cnt == MCW'(MOVE_DIV - 1));
    moved   = step && (go_l ? (pos_x > 10'(X_MIN)) : (pos_x < 10'(X_MAX)));
    tick    = (st == AIR) && (grav_cnt == GCW'(GRAV_DIV - 1));
    launch  = (st != AIR) && btn_jump && !jump_q && (cool == '0);

    vel_x = $signed({{(11 - VW){vel[VW-1]}}, vel});
    ny    = $signed({1'b0, pos_y}) + vel_x;
    vel_g = vel_x + 11'(G);
    land  = tick && (ny >= 11'(GROUND_Y));
    bump  = tick && !land && (ny < 11'(Y_MIN));

    st_n = st;
    if (launch)
      st_n = AIR;
    else if (st != AIR || land)
      st_n = dir_act ? WALK : IDLE;

    facing_n = go_l ? 1'b1 : (go_r ? 1'b0 : facing);

    // Animation bookkeeping only lives in WALK; any other next state wipes it.
    walk_phase_n = walk_phase;
    step_cnt_n   = step_cnt;
    if (st_n != WALK) begin
      walk_phase_n = 1'b0;
      step_cnt_n   = '0;
    end else if (moved) begin
      if (step_cnt == SCW'(ANIM_STEPS - 1)) begin
        step_cnt_n   = '0;
        walk_phase_n = ~walk_phase;
      end else begin
        step_cnt_n = step_cnt + 1'b1;
      end
    end

    if (st_n == AIR)
      sel_n = {2'b10, facing_n};
    else if (st_n == WALK && !walk_phase_n)
      sel_n = {2'b01, facing_n};
    else
      sel_n = {2'b00, facing_n};

    // A raster position left of / above the box wraps to a large offset, so one compare per axis suffices.
    dx     = {1'b0, hCount} - {1'b0, disp_x};
    dy     = {1'b0, vCount} - {1'b0, disp_y};
    hit    = (dx < 11'(SPR_W)) && (dy < 11'(SPR_H));
    addr_c = ADDR_W'(dy) * ADDR_W'(SPR_W) + ADDR_W'(dx);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st          <= IDLE;
      pos_x       <= 10'(X_INIT);
      pos_y       <= 10'(GROUND_Y);
      vel         <= '0;
      facing      <= 1'b0;
      sprite_sel  <= 3'd0;
      move_cnt    <= '0;
      grav_cnt    <= '0;
      cool        <= '0;
      step_cnt    <= '0;
      walk_phase  <= 1'b0;
      jump_q      <= 1'b0;
      disp_x      <= 10'(X_INIT);
      disp_y      <= 10'(GROUND_Y);
      sprite_addr <= '0;
      in_sprite   <= 1'b0;
    end else begin
      st         <= st_n;
      facing     <= facing_n;
      sprite_sel <= sel_n;
      step_cnt   <= step_cnt_n;
      walk_phase <= walk_phase_n;
      jump_q     <= btn_jump;
      move_cnt   <= (!dir_act || step) ? '0 : move_cnt + 1'b1;

      if (moved)
        pos_x <= go_l ? pos_x - 10'd1 : pos_x + 10'd1;

      if (launch) begin
        vel      <= -VW'(V_INIT);
        grav_cnt <= '0;
      end else if (st != AIR) begin
        grav_cnt <= '0;
      end else begin
        grav_cnt <= tick ? '0 : grav_cnt + 1'b1;
        if (land) begin
          pos_y <= 10'(GROUND_Y);
          vel   <= '0;
        end else if (bump) begin
          pos_y <= 10'(Y_MIN);
          vel   <= '0;
        end else if (tick) begin
          pos_y <= ny[9:0];
          vel   <= (vel_g > 11'(V_MAX)) ? VW'(V_MAX) : vel_g[VW-1:0];
        end
      end

      // Loading on landing also swallows a jump edge arriving on the same clk.
      if (land)
        cool <= CDW'(COOLDOWN);
      else if (cool != '0)
        cool <= cool - 1'b1;

      if (hCount == 10'd0 && vCount == 10'd0) begin
        disp_x <= pos_x;
        disp_y <= pos_y;
      end

      in_sprite   <= hit;
      sprite_addr <= hit ? addr_c : '0;
    end
  end

endmodule

// File: tb/tb_sprite_actor_ctrl.sv
// Bench for sprite_actor_ctrl: directed scenarios, a raster vector table, and randomized runs against a reference model.
module tb_sprite_actor_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       btn_left = 1'b0, btn_right = 1'b0, btn_jump = 1'b0;
  logic [9:0] hCount = 10'd1000, vCount = 10'd1000;
  logic [9:0] pos_x, pos_y;
  logic       facing;
  logic [1:0] state;
  logic [2:0] sprite_sel;
  logic [9:0] sprite_addr;
  logic       in_sprite;

  sprite_actor_ctrl #(.MOVE_DIV(4), .GRAV_DIV(4), .COOLDOWN(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .btn_left(btn_left), .btn_right(btn_right), .btn_jump(btn_jump),
    .hCount(hCount), .vCount(vCount),
    .pos_x(pos_x), .pos_y(pos_y), .facing(facing), .state(state),
    .sprite_sel(sprite_sel), .sprite_addr(sprite_addr), .in_sprite(in_sprite)
  );

  always #5 clk = ~clk;

  int n_tot = 0, n_pass = 0;
  bit chk_model = 1'b0;

  // Reference model state (screen coordinates, signed velocity, state as 0/1/2).
  int m_x, m_y, m_vel, m_state, m_face, m_phase, m_steps, m_mcnt, m_gcnt, m_cool, m_jprev;
  int m_dx, m_dy, m_addr, m_in, m_sel;

  typedef struct {
    int hc;
    int vc;
    int exp_in;
    int exp_addr;
  } pix_vec_t;
  pix_vec_t pix_tab[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic model_reset();
    m_x = 300; m_y = 460; m_vel = 0; m_state = 0; m_face = 0; m_phase = 0; m_steps = 0;
    m_mcnt = 0; m_gcnt = 0; m_cool = 0; m_jprev = 0;
    m_dx = 300; m_dy = 460; m_addr = 0; m_in = 0; m_sel = 0;
  endtask

  task automatic model_edge();
    int dir, hc, vc, nx, ny, nv, ns, nc, t;
    bit moved;
    hc  = int'(hCount);
    vc  = int'(vCount);
    dir = (btn_left && !btn_right) ? -1 : ((btn_right && !btn_left) ? 1 : 0);
    if (hc >= m_dx && hc < m_dx + 32 && vc >= m_dy && vc < m_dy + 32) begin
      m_in = 1; m_addr = (vc - m_dy) * 32 + (hc - m_dx);
    end else begin
      m_in = 0; m_addr = 0;
    end
    if (hc == 0 && vc == 0) begin m_dx = m_x; m_dy = m_y; end
    moved = 0; nx = m_x;
    if (dir == 0) m_mcnt = 0;
    else if (m_mcnt == 3) begin
      m_mcnt = 0;
      if (m_x + dir >= 143 && m_x + dir <= 702) begin nx = m_x + dir; moved = 1; end
    end else m_mcnt++;
    if (dir != 0) m_face = (dir < 0) ? 1 : 0;
    ny = m_y; nv = m_vel; ns = m_state;
    nc = (m_cool > 0) ? m_cool - 1 : 0;
    if (m_state != 2) begin
      m_gcnt = 0;
      if (btn_jump && m_jprev == 0 && m_cool == 0) begin ns = 2; nv = -15; end
      else ns = (dir != 0) ? 1 : 0;
    end else if (m_gcnt < 3) begin
      m_gcnt++;
    end else begin
      m_gcnt = 0;
      t = m_y + m_vel;
      if (t >= 460) begin ny = 460; nv = 0; nc = 8; ns = (dir != 0) ? 1 : 0; end
      else if (t < 35) begin ny = 35; nv = 0; end
      else begin ny = t; nv = (m_vel + 1 > 15) ? 15 : m_vel + 1; end
    end
    if (ns != 1) begin m_steps = 0; m_phase = 0; end
    else if (moved) begin
      m_steps++;
      if (m_steps == 5) begin m_steps = 0; m_phase ^= 1; end
    end
    m_x = nx; m_y = ny; m_vel = nv; m_state = ns; m_cool = nc; m_jprev = int'(btn_jump);
    m_sel = (ns == 2) ? 4 + m_face : ((ns == 1 && m_phase == 0) ? 2 + m_face : m_face);
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge();
    #1;
    if (chk_model) begin
      check("m_pos_x", pos_x, m_x);
      check("m_pos_y", pos_y, m_y);
      check("m_state", state, m_state);
      check("m_facing", facing, m_face);
      check("m_sprite_sel", sprite_sel, m_sel);
      check("m_in_sprite", in_sprite, m_in);
      check("m_sprite_addr", sprite_addr, m_addr);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    btn_left = 1'b0; btn_right = 1'b0; btn_jump = 1'b0;
    hCount = 10'd1000; vCount = 10'd1000;
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  initial begin
    int min_y;
    int prev_in;
    pix_tab[0]  = '{299, 460, 0, 0};
    pix_tab[1]  = '{300, 460, 1, 0};
    pix_tab[2]  = '{331, 491, 1, 1023};
    pix_tab[3]  = '{332, 491, 0, 0};
    pix_tab[4]  = '{300, 459, 0, 0};
    pix_tab[5]  = '{301, 460, 1, 1};
    pix_tab[6]  = '{300, 461, 1, 32};
    pix_tab[7]  = '{331, 460, 1, 31};
    pix_tab[8]  = '{315, 470, 1, 335};
    pix_tab[9]  = '{300, 492, 0, 0};
    pix_tab[10] = '{300, 491, 1, 992};
    pix_tab[11] = '{0, 0, 0, 0};

    // Reset values
    do_reset();
    check("rst_pos_x", pos_x, 300);
    check("rst_pos_y", pos_y, 460);
    check("rst_state", state, 0);
    check("rst_facing", facing, 0);
    check("rst_sel", sprite_sel, 0);
    check("rst_addr", sprite_addr, 0);
    check("rst_in", in_sprite, 0);

    // Raster table against the reset display latch (300,460)
    prev_in = 0;
    for (int i = 0; i < 12; i++) begin
      hCount = 10'(pix_tab[i].hc);
      vCount = 10'(pix_tab[i].vc);
      #1 check("pix_latency", in_sprite, prev_in);
      cyc();
      check("pix_in", in_sprite, pix_tab[i].exp_in);
      check("pix_addr", sprite_addr, pix_tab[i].exp_addr);
      prev_in = pix_tab[i].exp_in;
    end

    // Walk right
    do_reset();
    btn_right = 1'b1;
    for (int e = 1; e <= 40; e++) begin
      cyc();
      if (e == 1) begin check("walk_state", state, 1); check("walk_sel", sprite_sel, 2); end
      if (e == 4) check("walk_first_step", pos_x, 301);
      if (e == 19) check("walk_sel_pre5", sprite_sel, 2);
      if (e == 20) begin check("walk_x5", pos_x, 305); check("walk_sel_phase", sprite_sel, 0); end
      if (e == 40) begin check("walk_x10", pos_x, 310); check("walk_sel10", sprite_sel, 2); end
    end
    btn_right = 1'b0;

    // Walk left into the X_MIN clamp
    do_reset();
    btn_left = 1'b1;
    repeat (620) cyc();
    check("left_x145", pos_x, 145);
    check("left_facing", facing, 1);
    repeat (20) cyc();
    check("left_clamp_sel", sprite_sel, 1);
    check("left_x143", pos_x, 143);
    repeat (20) cyc();
    check("left_hold143", pos_x, 143);
    check("left_state", state, 1);
    btn_left = 1'b0;

    // Single jump pulse
    do_reset();
    btn_jump = 1'b1;
    cyc();
    check("jump_state", state, 2);
    check("jump_sel", sprite_sel, 4);
    btn_jump = 1'b0;
    min_y = 1000;
    for (int e = 2; e <= 125; e++) begin
      cyc();
      if (int'(pos_y) < min_y) min_y = int'(pos_y);
      if (e == 5) check("jump_tick1", pos_y, 445);
      if (e == 61) check("jump_peak", pos_y, 340);
      if (e == 124) check("jump_still_air", state, 2);
      if (e == 125) begin
        check("land_y", pos_y, 460);
        check("land_state", state, 0);
        check("land_sel", sprite_sel, 0);
      end
    end
    check("jump_min_y", min_y, 340);

    // Held jump, then cooldown gating
    do_reset();
    btn_jump = 1'b1;
    for (int e = 1; e <= 136; e++) begin
      cyc();
      if (e == 125) check("hold_land", state, 0);
      if (e == 136) check("hold_no_relaunch", state, 0);
    end
    btn_jump = 1'b0;
    cyc();
    btn_jump = 1'b1;
    cyc();
    check("second_launch", state, 2);
    btn_jump = 1'b0;
    repeat (124) cyc();
    check("second_land", state, 0);
    for (int r = 1; r <= 10; r++) begin
      btn_jump = (r == 3 || r == 8 || r == 10);
      cyc();
      if (r == 3 || r == 8) check("cool_block", state, 0);
      if (r == 10) check("cool_expired_launch", state, 2);
    end
    btn_jump = 1'b0;

    // Both buttons and reset mid-jump
    do_reset();
    btn_left = 1'b1;
    repeat (4) cyc();
    check("both_pre_x", pos_x, 299);
    btn_right = 1'b1;
    repeat (20) cyc();
    check("both_x", pos_x, 299);
    check("both_state", state, 0);
    check("both_facing", facing, 1);
    check("both_sel", sprite_sel, 1);
    btn_left = 1'b0; btn_right = 1'b0;
    btn_jump = 1'b1;
    cyc();
    btn_jump = 1'b0;
    repeat (30) cyc();
    rst_n = 1'b0;
    #1;
    check("midrst_pos_y", pos_y, 460);
    check("midrst_state", state, 0);
    model_reset();
    @(posedge clk);
    #2 rst_n = 1'b1;

    // Display latch only follows pos at frame start
    do_reset();
    btn_right = 1'b1;
    repeat (8) cyc();
    btn_right = 1'b0;
    hCount = 10'd300; vCount = 10'd460;
    cyc();
    check("frame_old_in", in_sprite, 1);
    check("frame_old_addr", sprite_addr, 0);
    hCount = 10'd0; vCount = 10'd0;
    cyc();
    hCount = 10'd300; vCount = 10'd460;
    cyc();
    check("frame_new_miss", in_sprite, 0);
    hCount = 10'd303; vCount = 10'd461;
    cyc();
    check("frame_new_in", in_sprite, 1);
    check("frame_new_addr", sprite_addr, 33);

    // Randomized run against the reference model
    do_reset();
    chk_model = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 15) == 0) btn_left = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 15) == 0) btn_right = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0) btn_jump = ~btn_jump;
      if ($urandom_range(0, 31) == 0) begin
        hCount = 10'd0; vCount = 10'd0;
      end else begin
        hCount = 10'(m_dx - 3 + int'($urandom_range(0, 38)));
        vCount = 10'(m_dy - 3 + int'($urandom_range(0, 38)));
      end
      cyc();
    end
    chk_model = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
